// File: rtl/lutnet_pkg.sv
// Shared types and sizing helpers for the programmable LUT neuron.
// Used by lut_neuron_prog and lut_neuron_mem (LUT_READBACK_EN build option lives in those files).
package lutnet_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } lut_state_e;

  function automatic int tbl_bits(input int in_bits, input int out_bits);
    return (1 << in_bits) * out_bits;
  endfunction

  function automatic int nwords(input int in_bits, input int out_bits, input int word_w);
    return tbl_bits(in_bits, out_bits) / word_w;
  endfunction

  // Never return zero so single-word tables still get a 1-bit index.
  function automatic int widx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lut_neuron_mem.sv
// Truth-table storage: word-wide synchronous write, registered entry lookup.
// With LUT_READBACK_EN defined an extra combinational word read port is exposed.
module lut_neuron_mem
  import lutnet_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int WORD_W   = 32,
  localparam int NW      = nwords(IN_BITS, OUT_BITS, WORD_W),
  localparam int AW      = widx_w(NW)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [WORD_W-1:0]   wdata_i,
  input  logic                re_i,
  input  logic [IN_BITS-1:0]  raddr_i,
`ifdef LUT_READBACK_EN
  input  logic [AW-1:0]       rb_addr_i,
  output logic [WORD_W-1:0]   rb_word_o,
`endif
  output logic [OUT_BITS-1:0] rdata_o
);

  localparam int TBL = tbl_bits(IN_BITS, OUT_BITS);

  logic [WORD_W-1:0]   mem_q [NW];
  logic [TBL-1:0]      tbl_s;
  logic [OUT_BITS-1:0] rdata_q;

  // Flatten words so an entry may be sliced regardless of word boundaries.
  always_comb begin
    tbl_s = '0;
    for (int k = 0; k < NW; k++) begin
      tbl_s[k*WORD_W +: WORD_W] = mem_q[k];
    end
  end

  // Table contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered lookup; holds its value between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= tbl_s[int'(raddr_i)*OUT_BITS +: OUT_BITS];
    end
  end

  assign rdata_o = rdata_q;

`ifdef LUT_READBACK_EN
  assign rb_word_o = mem_q[rb_addr_i];
`endif

endmodule

// File: rtl/lut_neuron_prog.sv
// Runtime-programmable LUT neuron: streamed table loader plus 1-cycle lookup.
// Define LUT_READBACK_EN to add the rb_* word readback stream.
module lut_neuron_prog
  import lutnet_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  output logic                cfg_err,
  output logic                loaded,
  input  logic                lk_valid,
  output logic                lk_ready,
  input  logic [IN_BITS-1:0]  lk_addr,
  output logic                out_valid,
`ifdef LUT_READBACK_EN
  input  logic                rb_req,
  output logic                rb_valid,
  input  logic                rb_ready,
  output logic [WORD_W-1:0]   rb_data,
  output logic                rb_last,
`endif
  output logic [OUT_BITS-1:0] out_data
);

  localparam int NW = nwords(IN_BITS, OUT_BITS, WORD_W);
  localparam int CW = widx_w(NW);
  localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

  lut_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic        cfg_err_q;
  logic        out_valid_q;
  logic        cfg_fire_s;
  logic        lk_fire_s;
  logic        at_last_s;

  assign cfg_fire_s = cfg_valid && cfg_ready;
  assign at_last_s  = (cnt_q == LAST_IDX);
  assign loaded     = (state_q == READY);
  assign lk_ready   = loaded;
  assign lk_fire_s  = lk_valid && lk_ready;
  assign cfg_err    = cfg_err_q;
  assign out_valid  = out_valid_q;

  // Loader FSM: any accepted word is written at the counter, then framing decides the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        EMPTY, LOAD, READY: begin
          if (cfg_fire_s) begin
            if (at_last_s && cfg_last) begin
              state_q <= READY;
              cnt_q   <= '0;
            end else if (at_last_s != cfg_last) begin
              state_q   <= EMPTY;
              cnt_q     <= '0;
              cfg_err_q <= 1'b1;
            end else begin
              state_q <= LOAD;
              cnt_q   <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= EMPTY;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Lookup result strobe; no backpressure on the result side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= lk_fire_s;
    end
  end

`ifdef LUT_READBACK_EN
  logic              rb_valid_q;
  logic              rb_last_q;
  logic [CW-1:0]     rb_idx_q;
  logic [WORD_W-1:0] rb_data_q;
  logic [WORD_W-1:0] rb_word_s;
  logic              rb_start_s;
  logic              rb_adv_s;

  // A reload word arriving alongside rb_req wins; the request is ignored.
  assign rb_start_s = rb_req && (state_q == READY) && !rb_valid_q && !cfg_fire_s;
  assign rb_adv_s   = rb_valid_q && rb_ready && !rb_last_q;
  assign cfg_ready  = !rb_valid_q;
  assign rb_valid   = rb_valid_q;
  assign rb_last    = rb_last_q;
  assign rb_data    = rb_data_q;

  // rb_idx_q always points at the next word to present; it rests at zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_valid_q <= 1'b0;
      rb_last_q  <= 1'b0;
      rb_idx_q   <= '0;
      rb_data_q  <= '0;
    end else if (rb_start_s || rb_adv_s) begin
      rb_valid_q <= 1'b1;
      rb_data_q  <= rb_word_s;
      rb_last_q  <= (rb_idx_q == LAST_IDX);
      rb_idx_q   <= (rb_idx_q == LAST_IDX) ? '0 : rb_idx_q + CW'(1);
    end else if (rb_valid_q && rb_ready) begin
      rb_valid_q <= 1'b0;
      rb_last_q  <= 1'b0;
    end else begin
      rb_valid_q <= rb_valid_q;
    end
  end
`else
  assign cfg_ready = 1'b1;
`endif

  lut_neuron_mem #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .WORD_W  (WORD_W)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (cfg_fire_s),
    .waddr_i  (cnt_q),
    .wdata_i  (cfg_data),
    .re_i     (lk_fire_s),
    .raddr_i  (lk_addr),
`ifdef LUT_READBACK_EN
    .rb_addr_i(rb_idx_q),
    .rb_word_o(rb_word_s),
`endif
    .rdata_o  (out_data)
  );

endmodule
